// File: rtl/wired_inst_queue_if.sv
// Fetch-to-decode bundle for the instruction queue: icache packet side, decode side and flush.
// Exception nibble layout is {adef, tlbr, pif, ppi}.
interface wired_inst_queue_if #(
   parameter int PACKED_SIZE = 32
);
   logic                        flush_i;

   logic                        f_valid_i;
   logic                        f_ready_o;
   logic [1:0]                  f_mask_i;
   logic [31:0]                 f_pc_i;
   logic [1:0][31:0]            f_inst_i;
   logic [PACKED_SIZE-1:0]      f_pkg_i;
   logic [3:0]                  f_excp_i;

   logic [1:0]                  d_valid_o;
   logic                        d_ready_i;
   logic [1:0][31:0]            d_pc_o;
   logic [1:0][31:0]            d_inst_o;
   logic [1:0][PACKED_SIZE-1:0] d_pkg_o;
   logic [1:0][3:0]             d_excp_o;

   modport master (
      output flush_i,
      output f_valid_i, f_mask_i, f_pc_i, f_inst_i, f_pkg_i, f_excp_i,
      output d_ready_i,
      input  f_ready_o,
      input  d_valid_o, d_pc_o, d_inst_o, d_pkg_o, d_excp_o
   );

   modport slave (
      input  flush_i,
      input  f_valid_i, f_mask_i, f_pc_i, f_inst_i, f_pkg_i, f_excp_i,
      input  d_ready_i,
      output f_ready_o,
      output d_valid_o, d_pc_o, d_inst_o, d_pkg_o, d_excp_o
   );
endinterface

// File: rtl/wired_inst_queue.sv
// Fetch-side instruction queue: compacts 2-wide icache packets into single-instruction
// entries and presents up to two in-order instructions per cycle to decode.
module wired_inst_queue #(
   parameter int DEPTH       = 8,
   parameter int PACKED_SIZE = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   wired_inst_queue_if.slave  iq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

   // Entry storage; pc keeps only [31:2] since instructions are word aligned
   logic [29:0]            pc_mem   [DEPTH];
   logic [31:0]            inst_mem [DEPTH];
   logic [PACKED_SIZE-1:0] pkg_mem  [DEPTH];
   logic [3:0]             excp_mem [DEPTH];

   logic [PW-1:0] head_reg, head_next;
   logic [PW-1:0] tail_reg, tail_next;
   logic [CW-1:0] count_reg, count_next;

   logic [PW-1:0] head_p1;
   logic [PW-1:0] tail_p1;
   logic          f_ready;
   logic          enq_fire;
   logic [1:0]    enq_n;
   logic [1:0]    deq_n;
   logic [1:0]    d_valid;
   logic          head_excp;
   logic          head_p1_excp;
   logic          lane_a;
   logic [DEPTH-1:0] wr_a;
   logic [DEPTH-1:0] wr_b;
   logic [2:0]    pc_lo_unused;

   assign pc_lo_unused = iq.f_pc_i[2:0];

   assign head_p1 = head_reg + PW'(1);
   assign tail_p1 = tail_reg + PW'(1);

   // Ready depends on registered occupancy only, leaving room for a full 2-word packet
   assign f_ready  = (count_reg <= READY_MAX);
   assign enq_fire = iq.f_valid_i && f_ready && !iq.flush_i;
   assign enq_n    = enq_fire ? ({1'b0, iq.f_mask_i[0]} + {1'b0, iq.f_mask_i[1]}) : 2'd0;

   // The first written word is lane 0 when present, otherwise lane 1
   assign lane_a = ~iq.f_mask_i[0];

   assign head_excp    = |excp_mem[head_reg];
   assign head_p1_excp = |excp_mem[head_p1];

   // An excepting instruction never pairs: it travels alone in lane 0
   assign d_valid[0] = (count_reg != '0);
   assign d_valid[1] = (count_reg >= CW'(2)) && !head_excp && !head_p1_excp;

   assign deq_n = (iq.d_ready_i && !iq.flush_i) ?
                  ({1'b0, d_valid[0]} + {1'b0, d_valid[1]}) : 2'd0;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_a[gi] = (enq_n != 2'd0) && (tail_reg == PW'(gi));
         assign wr_b[gi] = (enq_n == 2'd2) && (tail_p1 == PW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_a[i]) begin
            pc_mem[i]   <= {iq.f_pc_i[31:3], lane_a};
            inst_mem[i] <= iq.f_inst_i[lane_a];
            pkg_mem[i]  <= iq.f_pkg_i;
            excp_mem[i] <= iq.f_excp_i;
         end else if (wr_b[i]) begin
            pc_mem[i]   <= {iq.f_pc_i[31:3], 1'b1};
            inst_mem[i] <= iq.f_inst_i[1];
            pkg_mem[i]  <= iq.f_pkg_i;
            excp_mem[i] <= iq.f_excp_i;
         end
      end
   end

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (iq.flush_i) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         head_next  = head_reg + PW'(deq_n);
         tail_next  = tail_reg + PW'(enq_n);
         count_next = count_reg + CW'(enq_n) - CW'(deq_n);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign iq.f_ready_o = f_ready;
   assign iq.d_valid_o = d_valid;

   // Lane 0 reads head, lane 1 reads head+1; data is stale whenever its valid is low
   assign iq.d_pc_o[0]   = {pc_mem[head_reg], 2'b00};
   assign iq.d_pc_o[1]   = {pc_mem[head_p1], 2'b00};
   assign iq.d_inst_o[0] = inst_mem[head_reg];
   assign iq.d_inst_o[1] = inst_mem[head_p1];
   assign iq.d_pkg_o[0]  = pkg_mem[head_reg];
   assign iq.d_pkg_o[1]  = pkg_mem[head_p1];
   assign iq.d_excp_o[0] = excp_mem[head_reg];
   assign iq.d_excp_o[1] = excp_mem[head_p1];
endmodule

// File: tb/tb_wired_inst_queue.sv
// Directed-vector bench for wired_inst_queue; inputs change and outputs are sampled on negedge.
module tb_wired_inst_queue;
   localparam int DEPTH = 8;
   localparam int PS    = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wired_inst_queue_if #(.PACKED_SIZE(PS)) bus ();

   wired_inst_queue #(.DEPTH(DEPTH), .PACKED_SIZE(PS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .iq    (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return {8'hE7, pc[23:0]};
   endfunction

   function automatic logic [31:0] pkg_of(input logic [31:0] pc);
      return ~{pc[31:3], 3'b000};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] pc, input logic [1:0] mask, input logic [3:0] excp);
      bus.f_valid_i   = 1'b1;
      bus.f_pc_i      = pc;
      bus.f_mask_i    = mask;
      bus.f_inst_i[0] = inst_of({pc[31:3], 3'b000});
      bus.f_inst_i[1] = inst_of({pc[31:3], 3'b100});
      bus.f_pkg_i     = pkg_of(pc);
      bus.f_excp_i    = excp;
      $display("pkt pc=%08h mask=%b excp=%b ready=%b", pc, mask, excp, bus.f_ready_o);
   endtask

   task automatic idle();
      bus.f_valid_i = 1'b0;
      bus.f_mask_i  = 2'b00;
      bus.f_excp_i  = 4'b0000;
   endtask

   task automatic expect_out(input string tag, input logic [1:0] v, input logic [31:0] pc0,
                             input logic [31:0] pc1, input logic [3:0] excp0);
      check({tag, ".valid"}, bus.d_valid_o, v);
      if (v[0]) begin
         check({tag, ".pc0"},   bus.d_pc_o[0],   pc0);
         check({tag, ".inst0"}, bus.d_inst_o[0], inst_of(pc0));
         check({tag, ".pkg0"},  bus.d_pkg_o[0],  pkg_of(pc0));
         check({tag, ".excp0"}, bus.d_excp_o[0], excp0);
      end
      if (v[1]) begin
         check({tag, ".pc1"},   bus.d_pc_o[1],   pc1);
         check({tag, ".inst1"}, bus.d_inst_o[1], inst_of(pc1));
         check({tag, ".excp1"}, bus.d_excp_o[1], 4'b0000);
      end
      $display("out %s valid=%b pc0=%08h pc1=%08h", tag, bus.d_valid_o, bus.d_pc_o[0], bus.d_pc_o[1]);
   endtask

   // Invariants checked every cycle outside reset
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("lane1_alone", {63'd0, bus.d_valid_o == 2'b10}, 64'd0);
         check("count_le_depth", {63'd0, dut.count_reg <= DEPTH}, 64'd1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flush_i   = 1'b0;
      bus.d_ready_i = 1'b0;
      bus.f_pc_i    = '0;
      bus.f_inst_i  = '0;
      bus.f_pkg_i   = '0;
      idle();

      // Reset
      rst_n = 1'b0;
      tick(); tick();
      check("rst.valid", bus.d_valid_o, 2'b00);
      check("rst.ready", bus.f_ready_o, 1'b1);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // 1: two full packets streaming with no decode stall
      bus.d_ready_i = 1'b1;
      send(32'h1000, 2'b11, 4'h0);
      tick();
      expect_out("t1a", 2'b11, 32'h1000, 32'h1004, 4'h0);
      send(32'h1008, 2'b11, 4'h0);
      tick();
      expect_out("t1b", 2'b11, 32'h1008, 32'h100C, 4'h0);
      idle();
      tick();
      expect_out("t1c", 2'b00, 32'h0, 32'h0, 4'h0);
      check("t1.ready", bus.f_ready_o, 1'b1);

      // 2: single-word packets compact into one group
      bus.d_ready_i = 1'b0;
      send(32'h2004, 2'b10, 4'h0);
      tick();
      expect_out("t2a", 2'b01, 32'h2004, 32'h0, 4'h0);
      send(32'h2008, 2'b01, 4'h0);
      tick();
      expect_out("t2b", 2'b11, 32'h2004, 32'h2008, 4'h0);
      idle();
      bus.d_ready_i = 1'b1;
      tick();
      expect_out("t2c", 2'b00, 32'h0, 32'h0, 4'h0);

      // 3: fill under decode stall, then drain across the pointer wrap
      bus.d_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t3.ready_fill", bus.f_ready_o, 1'b1);
         send(32'h3000 + 32'(k * 8), 2'b11, 4'h0);
         tick();
      end
      check("t3.ready_full", bus.f_ready_o, 1'b0);
      send(32'h3F00, 2'b11, 4'h0);
      tick();
      idle();
      check("t3.ready_hold", bus.f_ready_o, 1'b0);
      bus.d_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expect_out("t3.drain", 2'b11, 32'h3000 + 32'(k * 8), 32'h3004 + 32'(k * 8), 4'h0);
         if (k == 1) check("t3.ready_back", bus.f_ready_o, 1'b1);
         tick();
      end
      expect_out("t3.empty", 2'b00, 32'h0, 32'h0, 4'h0);
      bus.d_ready_i = 1'b0;

      // 4: exception in head issues alone; exception in head+1 also blocks pairing
      send(32'h4000, 2'b01, 4'b0100);
      tick();
      send(32'h4004, 2'b10, 4'b0000);
      tick();
      idle();
      expect_out("t4a", 2'b01, 32'h4000, 32'h0, 4'b0100);
      bus.d_ready_i = 1'b1;
      tick();
      expect_out("t4b", 2'b01, 32'h4004, 32'h0, 4'b0000);
      tick();
      bus.d_ready_i = 1'b0;
      expect_out("t4c", 2'b00, 32'h0, 32'h0, 4'h0);
      send(32'h4100, 2'b01, 4'b0000);
      tick();
      send(32'h4108, 2'b01, 4'b0001);
      tick();
      idle();
      expect_out("t4d", 2'b01, 32'h4100, 32'h0, 4'b0000);
      bus.d_ready_i = 1'b1;
      tick();
      expect_out("t4e", 2'b01, 32'h4108, 32'h0, 4'b0001);
      tick();
      bus.d_ready_i = 1'b0;
      expect_out("t4f", 2'b00, 32'h0, 32'h0, 4'h0);

      // 5: flush with count=5 and a same-cycle packet
      send(32'h5000, 2'b11, 4'h0);
      tick();
      send(32'h5008, 2'b11, 4'h0);
      tick();
      send(32'h5010, 2'b01, 4'h0);
      tick();
      check("t5.ready_cnt5", bus.f_ready_o, 1'b1);
      send(32'h5018, 2'b11, 4'h0);
      bus.flush_i   = 1'b1;
      bus.d_ready_i = 1'b1;
      tick();
      bus.flush_i   = 1'b0;
      bus.d_ready_i = 1'b0;
      expect_out("t5a", 2'b00, 32'h0, 32'h0, 4'h0);
      check("t5.ready", bus.f_ready_o, 1'b1);
      send(32'h5100, 2'b11, 4'h0);
      tick();
      idle();
      expect_out("t5b", 2'b11, 32'h5100, 32'h5104, 4'h0);
      bus.d_ready_i = 1'b1;
      tick();
      bus.d_ready_i = 1'b0;
      expect_out("t5c", 2'b00, 32'h0, 32'h0, 4'h0);

      // 6: empty-mask packet writes nothing; reset mid-stream
      send(32'h6000, 2'b00, 4'h0);
      tick();
      expect_out("t6a", 2'b00, 32'h0, 32'h0, 4'h0);
      send(32'h6008, 2'b01, 4'h0);
      tick();
      idle();
      expect_out("t6b", 2'b01, 32'h6008, 32'h0, 4'h0);
      rst_n = 1'b0;
      tick();
      check("t6.rst_valid", bus.d_valid_o, 2'b00);
      check("t6.rst_ready", bus.f_ready_o, 1'b1);
      rst_n = 1'b1;
      tick();
      expect_out("t6c", 2'b00, 32'h0, 32'h0, 4'h0);
      check("t6.ready", bus.f_ready_o, 1'b1);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
